// File: rtl/syn_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count and almost-full/empty flags.
// Define SYN_FIFO_STATUS_EN to build the sticky overflow/underflow error registers.
module syn_fifo_param #(
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned DEPTH    = 8,
   parameter int unsigned AF_LEVEL = 6,
   parameter int unsigned AE_LEVEL = 2
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       write_e,
   input  logic [DATA_W-1:0]          data_in,
   input  logic                       read_e,
   output logic [DATA_W-1:0]          data_out,
   output logic                       full,
   output logic                       empty,
   output logic                       almost_full,
   output logic                       almost_empty,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       overflow,
   output logic                       underflow
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [AW:0]       wr_ptr_q, wr_ptr_d;
   logic [AW:0]       rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              wr_ok, rd_ok;

   // Flags come straight from the registered occupancy, so they lag a transfer by one edge.
   assign full         = (count_q == CW'(DEPTH));
   assign empty        = (count_q == '0);
   assign almost_full  = (count_q >= CW'(AF_LEVEL));
   assign almost_empty = (count_q <= CW'(AE_LEVEL));
   assign count        = count_q;
   assign data_out     = data_q;

   assign wr_ok = write_e & ~full;
   assign rd_ok = read_e & ~empty;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      data_d   = data_q;
      if (wr_ok) begin
         wr_ptr_d = wr_ptr_q + CW'(1);
      end
      if (rd_ok) begin
         rd_ptr_d = rd_ptr_q + CW'(1);
         data_d   = mem_q[rd_ptr_q[AW-1:0]];
      end
      case ({wr_ok, rd_ok})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         data_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         data_q   <= data_d;
      end
   end

   // Storage has no reset; a write coinciding with reset is dropped.
   always_ff @(posedge clk) begin
      if (reset_n && wr_ok) begin
         mem_q[wr_ptr_q[AW-1:0]] <= data_in;
      end
   end

`ifdef SYN_FIFO_STATUS_EN
   logic overflow_q, overflow_d;
   logic underflow_q, underflow_d;

   always_comb begin
      overflow_d  = overflow_q | (write_e & full);
      underflow_d = underflow_q | (read_e & empty);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   assign overflow  = overflow_q;
   assign underflow = underflow_q;
`else
   assign overflow  = 1'b0;
   assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_syn_fifo_param.sv
// Directed self-checking bench for syn_fifo_param: default 8x8 instance and a 16x16 instance.
module tb_syn_fifo_param;

`ifdef SYN_FIFO_STATUS_EN
   localparam logic STATUS_EN = 1'b1;
`else
   localparam logic STATUS_EN = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Instance A: defaults (DATA_W=8, DEPTH=8, AF=6, AE=2)
   logic       a_rst_n, a_we, a_re;
   logic [7:0] a_din, a_dout;
   logic       a_full, a_empty, a_af, a_ae, a_ov, a_un;
   logic [3:0] a_cnt;

   // Instance B: DATA_W=16, DEPTH=16, AF=12, AE=4
   logic        b_rst_n, b_we, b_re;
   logic [15:0] b_din, b_dout;
   logic        b_full, b_empty, b_af, b_ae, b_ov, b_un;
   logic [4:0]  b_cnt;

   syn_fifo_param u_dut_a (
      .clk          (clk),
      .reset_n      (a_rst_n),
      .write_e      (a_we),
      .data_in      (a_din),
      .read_e       (a_re),
      .data_out     (a_dout),
      .full         (a_full),
      .empty        (a_empty),
      .almost_full  (a_af),
      .almost_empty (a_ae),
      .count        (a_cnt),
      .overflow     (a_ov),
      .underflow    (a_un)
   );

   syn_fifo_param #(
      .DATA_W   (16),
      .DEPTH    (16),
      .AF_LEVEL (12),
      .AE_LEVEL (4)
   ) u_dut_b (
      .clk          (clk),
      .reset_n      (b_rst_n),
      .write_e      (b_we),
      .data_in      (b_din),
      .read_e       (b_re),
      .data_out     (b_dout),
      .full         (b_full),
      .empty        (b_empty),
      .almost_full  (b_af),
      .almost_empty (b_ae),
      .count        (b_cnt),
      .overflow     (b_ov),
      .underflow    (b_un)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Advance one rising edge and settle just after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic a_drive(input logic we, input logic re, input logic [7:0] d);
      a_we  = we;
      a_re  = re;
      a_din = d;
      tick();
      a_we  = 1'b0;
      a_re  = 1'b0;
   endtask

   task automatic a_reset();
      a_rst_n = 1'b0;
      tick();
      a_rst_n = 1'b1;
   endtask

   task automatic a_check_reset(input string tag);
      check({tag, "_count"}, 32'(a_cnt), 32'd0);
      check({tag, "_empty"}, 32'(a_empty), 32'd1);
      check({tag, "_full"}, 32'(a_full), 32'd0);
      check({tag, "_ae"}, 32'(a_ae), 32'd1);
      check({tag, "_af"}, 32'(a_af), 32'd0);
      check({tag, "_dout"}, 32'(a_dout), 32'd0);
      check({tag, "_ov"}, 32'(a_ov), 32'd0);
      check({tag, "_un"}, 32'(a_un), 32'd0);
   endtask

   initial begin
      a_rst_n = 1'b1; a_we = 1'b0; a_re = 1'b0; a_din = '0;
      b_rst_n = 1'b0; b_we = 1'b0; b_re = 1'b0; b_din = '0;

      // Reset
      a_reset();
      a_check_reset("rst");

      // Fill 0x01..0x08
      for (int i = 1; i <= 8; i++) begin
         a_drive(1'b1, 1'b0, 8'(i));
         check("fill_count", 32'(a_cnt), 32'(i));
         check("fill_af", 32'(a_af), 32'(i >= 6));
         check("fill_ae", 32'(a_ae), 32'(i <= 2));
         check("fill_full", 32'(a_full), 32'(i == 8));
         check("fill_empty", 32'(a_empty), 32'd0);
      end
      check("fill_ov_clear", 32'(a_ov), 32'd0);

      // Write while full is rejected
      a_drive(1'b1, 1'b0, 8'hFF);
      check("ovf_count", 32'(a_cnt), 32'd8);
      check("ovf_full", 32'(a_full), 32'd1);
      check("ovf_flag", 32'(a_ov), 32'(STATUS_EN));

      // Drain
      for (int i = 1; i <= 8; i++) begin
         a_drive(1'b0, 1'b1, 8'h00);
         check("drain_dout", 32'(a_dout), 32'(i));
         check("drain_count", 32'(a_cnt), 32'(8 - i));
         check("drain_empty", 32'(a_empty), 32'(i == 8));
         check("drain_un_clear", 32'(a_un), 32'd0);
      end

      // Read while empty is rejected
      a_drive(1'b0, 1'b1, 8'h00);
      check("unf_dout", 32'(a_dout), 32'h08);
      check("unf_count", 32'(a_cnt), 32'd0);
      check("unf_flag", 32'(a_un), 32'(STATUS_EN));
      check("unf_ov_sticky", 32'(a_ov), 32'(STATUS_EN));

      // Simultaneous traffic at count=4 across several pointer wraps
      a_reset();
      for (int i = 0; i < 4; i++) a_drive(1'b1, 1'b0, 8'(8'h10 + i));
      check("sim_pre_count", 32'(a_cnt), 32'd4);
      for (int k = 0; k < 20; k++) begin
         a_drive(1'b1, 1'b1, 8'(8'h14 + k));
         check("sim_dout", 32'(a_dout), 32'(8'h10 + k));
         check("sim_count", 32'(a_cnt), 32'd4);
      end
      for (int i = 0; i < 4; i++) begin
         a_drive(1'b0, 1'b1, 8'h00);
         check("sim_tail_dout", 32'(a_dout), 32'(8'h24 + i));
      end
      check("sim_empty", 32'(a_empty), 32'd1);
      check("sim_ov", 32'(a_ov), 32'd0);
      check("sim_un", 32'(a_un), 32'd0);

      // Full-boundary collision: read accepted, write rejected
      a_reset();
      for (int i = 0; i < 8; i++) a_drive(1'b1, 1'b0, 8'(8'h30 + i));
      a_drive(1'b1, 1'b1, 8'hEE);
      check("fcol_count", 32'(a_cnt), 32'd7);
      check("fcol_full", 32'(a_full), 32'd0);
      check("fcol_dout", 32'(a_dout), 32'h30);
      check("fcol_ov", 32'(a_ov), 32'(STATUS_EN));
      for (int i = 1; i < 8; i++) begin
         a_drive(1'b0, 1'b1, 8'h00);
         check("fcol_drain", 32'(a_dout), 32'(8'h30 + i));
      end
      check("fcol_empty", 32'(a_empty), 32'd1);
      check("fcol_un_clear", 32'(a_un), 32'd0);

      // Empty-boundary collision: write accepted, read rejected
      a_drive(1'b1, 1'b1, 8'h55);
      check("ecol_count", 32'(a_cnt), 32'd1);
      check("ecol_dout", 32'(a_dout), 32'h37);
      check("ecol_empty", 32'(a_empty), 32'd0);
      check("ecol_un", 32'(a_un), 32'(STATUS_EN));
      a_drive(1'b0, 1'b1, 8'h00);
      check("ecol_read", 32'(a_dout), 32'h55);

      // Reset mid-operation with a concurrent write
      a_reset();
      for (int i = 0; i < 5; i++) a_drive(1'b1, 1'b0, 8'(8'h60 + i));
      a_drive(1'b0, 1'b1, 8'h00);
      check("mid_pre_dout", 32'(a_dout), 32'h60);
      check("mid_pre_count", 32'(a_cnt), 32'd4);
      a_rst_n = 1'b0;
      a_drive(1'b1, 1'b0, 8'h99);
      a_rst_n = 1'b1;
      a_check_reset("mid");
      a_drive(1'b1, 1'b0, 8'h42);
      a_drive(1'b0, 1'b1, 8'h00);
      check("mid_post_dout", 32'(a_dout), 32'h42);
      check("mid_post_count", 32'(a_cnt), 32'd0);

      // Instance B: fill/drain with alternate parameters
      b_rst_n = 1'b0;
      tick();
      b_rst_n = 1'b1;
      check("b_rst_count", 32'(b_cnt), 32'd0);
      check("b_rst_empty", 32'(b_empty), 32'd1);
      check("b_rst_ae", 32'(b_ae), 32'd1);
      check("b_rst_af", 32'(b_af), 32'd0);
      for (int i = 1; i <= 16; i++) begin
         b_we = 1'b1; b_din = 16'(16'hA500 + i);
         tick();
         b_we = 1'b0;
         check("b_fill_count", 32'(b_cnt), 32'(i));
         check("b_fill_af", 32'(b_af), 32'(i >= 12));
         check("b_fill_ae", 32'(b_ae), 32'(i <= 4));
         check("b_fill_full", 32'(b_full), 32'(i == 16));
      end
      b_we = 1'b1; b_din = 16'hFFFF;
      tick();
      b_we = 1'b0;
      check("b_ovf_count", 32'(b_cnt), 32'd16);
      check("b_ovf_flag", 32'(b_ov), 32'(STATUS_EN));
      for (int i = 1; i <= 16; i++) begin
         b_re = 1'b1;
         tick();
         b_re = 1'b0;
         check("b_drain_dout", 32'(b_dout), 32'(16'hA500 + i));
         check("b_drain_count", 32'(b_cnt), 32'(16 - i));
         check("b_drain_ae", 32'(b_ae), 32'((16 - i) <= 4));
         check("b_drain_empty", 32'(b_empty), 32'(i == 16));
      end
      b_re = 1'b1;
      tick();
      b_re = 1'b0;
      check("b_unf_dout", 32'(b_dout), 32'hA510);
      check("b_unf_flag", 32'(b_un), 32'(STATUS_EN));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
